sa_host_loader: RTL

- Parametrised host-side sequencer for the systolic array top.
- Streams N×N operand matrices into memA/memB in diagonal-skewed, zero-padded layout, then loads the instruction memory.
- Pulses ap_start and waits for ap_done, then drains the N×N result words from the output memory onto a valid/ready stream.
- Replaces hand-sequenced bench stimulus with a reusable, backpressure-aware block for any array size.

---
 rtl/sa_pkg.sv | 23 ++
 rtl/sa_host_loader_if.sv | 41 ++++
 rtl/sa_skew_writer.sv | 61 ++++++
 rtl/sa_host_loader.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared types and constant helpers for the systolic-array host loader.
package sa_pkg;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_A, S_LOAD_B, S_LOAD_I, S_START, S_WAIT, S_DRAIN, S_DONE
    } state_e;

    typedef enum logic [1:0] {TGT_A, TGT_B, TGT_I} tgt_e;

    // Slots per skewed row: N data words plus N-1 zero pads.
    function automatic int slot_cnt(input int n);
        return 2 * n - 1;
    endfunction

    function automatic bit in_window(input int r, input int k, input int n);
        return (k >= r) && (k < r + n);
    endfunction

    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sa_host_loader_if.sv
// Host-side bus bundle: command, operand stream, result stream and array memory ports.
interface sa_host_loader_if #(
    parameter int N       = 4,
    parameter int DW      = 16,
    parameter int ROW_LEN = 256,
    parameter int IW      = 4,
    parameter int NI      = 8,
    parameter int OW      = 32,
    parameter int NO      = 128
);
    localparam int AW  = $clog2(N * ROW_LEN);
    localparam int IAW = $clog2(NI);
    localparam int OAW = $clog2(NO);

    logic           cmd_go, busy, err;
    logic           s_valid, s_ready;
    logic [DW-1:0]  s_data;
    logic           m_valid, m_ready, m_last;
    logic [OW-1:0]  m_data;
    logic [AW-1:0]  addrA, addrB;
    logic           enA, enB, enI;
    logic [DW-1:0]  dataA, dataB;
    logic [IAW-1:0] addrI;
    logic [IW-1:0]  dataI;
    logic [OAW-1:0] addrO;
    logic [OW-1:0]  dataO;
    logic           ap_start, ap_done;

    modport master (
        input  cmd_go, s_valid, s_data, m_ready, dataO, ap_done,
        output busy, err, s_ready, m_valid, m_data, m_last,
               addrA, enA, dataA, addrB, enB, dataB, addrI, enI, dataI, addrO, ap_start
    );

    modport slave (
        output cmd_go, s_valid, s_data, m_ready, dataO, ap_done,
        input  busy, err, s_ready, m_valid, m_data, m_last,
               addrA, enA, dataA, addrB, enB, dataB, addrI, enI, dataI, addrO, ap_start
    );

endinterface

// File: rtl/sa_skew_writer.sv
// Row/slot sequencer for one skewed operand matrix: in-window slots consume a
// stream word (stalling on !valid), out-of-window slots write zero and never stall.
module sa_skew_writer
    import sa_pkg::*;
#(
    parameter int N       = 4,
    parameter int DW      = 16,
    parameter int ROW_LEN = 256,
    parameter int AW      = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          active_i,
    input  logic          s_valid_i,
    input  logic [DW-1:0] s_data_i,
    output logic          s_ready_o,
    output logic [AW-1:0] addr_o,
    output logic          wen_o,
    output logic [DW-1:0] wdata_o,
    output logic          done_o
);
    localparam int SLOTS = slot_cnt(N);
    localparam int RW    = cnt_w(N);
    localparam int KW    = cnt_w(SLOTS);

    logic [RW-1:0] r_q, r_d;
    logic [KW-1:0] k_q, k_d;
    logic          in_win, adv, row_end;

    always_comb begin
        in_win    = in_window(int'(r_q), int'(k_q), N);
        adv       = active_i && (!in_win || s_valid_i);
        row_end   = (k_q == KW'(SLOTS - 1));
        s_ready_o = active_i && in_win;
        wen_o     = adv;
        wdata_o   = (active_i && in_win) ? s_data_i : '0;
        addr_o    = active_i ? AW'(int'(r_q) * ROW_LEN + int'(k_q)) : '0;
        done_o    = adv && row_end && (r_q == RW'(N - 1));
        r_d       = r_q;
        k_d       = k_q;
        if (adv) begin
            if (row_end) begin
                k_d = '0;
                r_d = done_o ? '0 : r_q + RW'(1);
            end else begin
                k_d = k_q + KW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
            k_q <= '0;
        end else begin
            r_q <= r_d;
            k_q <= k_d;
        end
    end

endmodule

// File: rtl/sa_host_loader.sv
// Load A/B (skewed) and instructions, kick the array, drain N*N results.
// Optional WAIT watchdog with sticky err: define SA_LOADER_TIMEOUT_EN (parameter TMO).
module sa_host_loader
    import sa_pkg::*;
#(
    parameter int N       = 4,
    parameter int DW      = 16,
    parameter int ROW_LEN = 256,
    parameter int IW      = 4,
    parameter int NI      = 8,
    parameter int OW      = 32,
    parameter int NO      = 128
`ifdef SA_LOADER_TIMEOUT_EN
    , parameter int TMO   = 4096
`endif
) (
    input logic              clk,
    input logic              rst,
    sa_host_loader_if.master bus
);
    localparam int AW  = $clog2(N * ROW_LEN);
    localparam int IAW = $clog2(NI);
    localparam int OAW = $clog2(NO);

    state_e         state_q, state_d;
    tgt_e           tgt;
    logic [IAW-1:0] icnt_q, icnt_d;
    logic [OAW-1:0] idx_q, idx_d;
    logic           pres_q, pres_d;
    logic           wr_act, wr_rdy, wr_en, wr_done;
    logic [AW-1:0]  wr_addr;
    logic [DW-1:0]  wr_data;

    always_comb begin
        case (state_q)
            S_LOAD_B: tgt = TGT_B;
            S_LOAD_I: tgt = TGT_I;
            default:  tgt = TGT_A;
        endcase
    end

    assign wr_act = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);

    // One writer serves both matrices; its counters wrap to zero after A.
    sa_skew_writer #(.N(N), .DW(DW), .ROW_LEN(ROW_LEN), .AW(AW)) u_wr (
        .clk(clk), .rst(rst), .active_i(wr_act), .s_valid_i(bus.s_valid),
        .s_data_i(bus.s_data), .s_ready_o(wr_rdy), .addr_o(wr_addr),
        .wen_o(wr_en), .wdata_o(wr_data), .done_o(wr_done)
    );

`ifdef SA_LOADER_TIMEOUT_EN
    localparam int TW = cnt_w(TMO);
    logic [TW-1:0] wcnt_q, wcnt_d;
    logic          err_q, err_d;
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        icnt_d       = icnt_q;
        idx_d        = idx_q;
        pres_d       = pres_q;
        bus.busy     = (state_q != S_IDLE);
        bus.s_ready  = 1'b0;
        bus.m_valid  = 1'b0;
        bus.m_data   = '0;
        bus.m_last   = 1'b0;
        bus.addrA    = '0;
        bus.enA      = 1'b0;
        bus.dataA    = '0;
        bus.addrB    = '0;
        bus.enB      = 1'b0;
        bus.dataB    = '0;
        bus.addrI    = '0;
        bus.enI      = 1'b0;
        bus.dataI    = '0;
        bus.addrO    = '0;
        bus.ap_start = 1'b0;
`ifdef SA_LOADER_TIMEOUT_EN
        wcnt_d       = '0;
        err_d        = err_q;
`endif
        case (state_q)
            S_IDLE: if (bus.cmd_go) state_d = S_LOAD_A;
            S_LOAD_A, S_LOAD_B: begin
                bus.s_ready = wr_rdy;
                if (tgt == TGT_A) begin
                    bus.addrA = wr_addr;
                    bus.enA   = wr_en;
                    bus.dataA = wr_data;
                end else begin
                    bus.addrB = wr_addr;
                    bus.enB   = wr_en;
                    bus.dataB = wr_data;
                end
                if (wr_done) state_d = (tgt == TGT_A) ? S_LOAD_B : S_LOAD_I;
            end
            S_LOAD_I: begin
                bus.s_ready = 1'b1;
                bus.addrI   = icnt_q;
                bus.enI     = bus.s_valid;
                bus.dataI   = bus.s_valid ? bus.s_data[IW-1:0] : '0;
                if (bus.s_valid) begin
                    if (icnt_q == IAW'(NI - 1)) begin
                        icnt_d  = '0;
                        state_d = S_START;
                    end else begin
                        icnt_d = icnt_q + IAW'(1);
                    end
                end
            end
            S_START: begin
                bus.ap_start = 1'b1;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                if (bus.ap_done) state_d = S_DRAIN;
`ifdef SA_LOADER_TIMEOUT_EN
                else if (wcnt_q == TW'(TMO - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else wcnt_d = wcnt_q + TW'(1);
`endif
            end
            S_DRAIN: begin
                // pres_q=0: address issued; pres_q=1: read data on the stream.
                bus.addrO   = idx_q;
                bus.m_valid = pres_q;
                bus.m_data  = pres_q ? bus.dataO : '0;
                bus.m_last  = pres_q && (idx_q == OAW'(N * N - 1));
                if (!pres_q) pres_d = 1'b1;
                else if (bus.m_ready) begin
                    pres_d = 1'b0;
                    if (idx_q == OAW'(N * N - 1)) begin
                        idx_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + OAW'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            icnt_q  <= '0;
            idx_q   <= '0;
            pres_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            icnt_q  <= icnt_d;
            idx_q   <= idx_d;
            pres_q  <= pres_d;
        end
    end

`ifdef SA_LOADER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            err_q  <= err_d;
        end
    end
`endif

endmodule
